pci_master_sched: RTL and testbench



---
 rtl/pci_pkg.sv | 13 +
 rtl/pci_rr_pick.sv | 30 +++
 rtl/pci_master_sched.sv | 152 +++++++++++++++
 tb/tb_pci_master_sched.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pci_pkg.sv
// Shared types and limits for the PCI Edu initiator-path scheduler.
package pci_pkg;

    localparam int unsigned PCI_MSCHED_MAX_REQ = 8;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StXfer,
        StTurn
    } pci_msched_state_t;

endpackage

// File: rtl/pci_rr_pick.sv
// Combinational cyclic priority picker: first set request bit at or after ptr, wrapping.
module pci_rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic            valid,
    output logic [N-1:0]    onehot,
    output logic [IdxW-1:0] idx
);

    logic [IdxW-1:0] cand;

    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        cand   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IdxW'((32'(ptr) + i) % N);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
        onehot[idx] = valid;
    end

endmodule

// File: rtl/pci_master_sched.sv
// Round-robin scheduler of the single PCI bus-master path among internal requesters,
// driving REQ/GNT toward the central arbiter and start pulses toward pci_busif.
module pci_master_sched
    import pci_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned RETRY_MAX = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         client_req,
    output logic [N_REQ-1:0]         client_gnt,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic                     req,
    input  logic                     gnt,
    input  logic                     frame_in,
    input  logic                     irdy_in,
    output logic                     start,
    input  logic                     xfer_done,
    input  logic                     xfer_retry
);

    localparam int unsigned IdxW     = $clog2(N_REQ);
    localparam logic [7:0]  RetryMax = RETRY_MAX[7:0];

    pci_msched_state_t state_q, state_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [7:0]        retry_cnt_q, retry_cnt_d;
    logic [N_REQ-1:0]  client_gnt_q, client_gnt_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic              busy_q, busy_d;
    logic              req_q, req_d;
    logic              start_q, start_d;

    logic              pick_valid;
    logic [N_REQ-1:0]  pick_onehot;
    logic [IdxW-1:0]   pick_idx;
    logic              bus_ok;
    logic              owner_req;
    logic [IdxW-1:0]   owner_inc;
    logic [7:0]        retry_inc;

    pci_rr_pick #(
        .N    (N_REQ),
        .IdxW (IdxW)
    ) u_pick (
        .req    (client_req),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    assign bus_ok    = gnt && !frame_in && !irdy_in;
    assign owner_req = client_req[owner_q];
    assign owner_inc = (owner_q == IdxW'(N_REQ - 1)) ? '0 : owner_q + IdxW'(1);
    assign retry_inc = (retry_cnt_q >= RetryMax) ? retry_cnt_q : retry_cnt_q + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            retry_cnt_q  <= '0;
            client_gnt_q <= '0;
            owner_q      <= '0;
            busy_q       <= 1'b0;
            req_q        <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            retry_cnt_q  <= retry_cnt_d;
            client_gnt_q <= client_gnt_d;
            owner_q      <= owner_d;
            busy_q       <= busy_d;
            req_q        <= req_d;
            start_q      <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (pick_valid) state_d = StReq;
            StReq: begin
                if (!owner_req) begin
                    state_d = StIdle;
                end else if (bus_ok) begin
                    state_d = StXfer;
                end
            end
            StXfer: if (xfer_done || xfer_retry) state_d = StTurn;
            StTurn: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ptr_d        = ptr_q;
        retry_cnt_d  = retry_cnt_q;
        client_gnt_d = client_gnt_q;
        owner_d      = owner_q;
        req_d        = req_q;
        start_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    client_gnt_d = pick_onehot;
                    owner_d      = pick_idx;
                    req_d        = 1'b1;
                    // Retry credit belongs to one owner only.
                    if (pick_idx != owner_q) retry_cnt_d = '0;
                end
            end
            StReq: begin
                if (!owner_req) begin
                    client_gnt_d = '0;
                    req_d        = 1'b0;
                end else if (bus_ok) begin
                    start_d = 1'b1;
                    req_d   = 1'b0;
                end
            end
            StXfer: begin
                if (xfer_done) begin
                    ptr_d        = owner_inc;
                    retry_cnt_d  = '0;
                    client_gnt_d = '0;
                end else if (xfer_retry) begin
                    client_gnt_d = '0;
                    if (retry_inc == RetryMax) begin
                        ptr_d       = owner_inc;
                        retry_cnt_d = '0;
                    end else begin
                        retry_cnt_d = retry_inc;
                    end
                end
            end
            StTurn: client_gnt_d = '0;
            default: ;
        endcase
        busy_d = (state_d != StIdle);
    end

    assign client_gnt = client_gnt_q;
    assign owner      = owner_q;
    assign busy       = busy_q;
    assign req        = req_q;
    assign start      = start_q;

endmodule

// File: tb/tb_pci_master_sched.sv
// Directed bench for pci_master_sched: vector table plus hand sequences for multi-cycle cases.
module tb_pci_master_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] client_req;
    logic [3:0] client_gnt;
    logic [1:0] owner;
    logic       busy, req, gnt, frame_in, irdy_in, start, xfer_done, xfer_retry;

    int total = 0;
    int bad   = 0;

    pci_master_sched #(
        .N_REQ     (4),
        .RETRY_MAX (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .client_req (client_req),
        .client_gnt (client_gnt),
        .owner      (owner),
        .busy       (busy),
        .req        (req),
        .gnt        (gnt),
        .frame_in   (frame_in),
        .irdy_in    (irdy_in),
        .start      (start),
        .xfer_done  (xfer_done),
        .xfer_retry (xfer_retry)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] creq;
        logic       gnt, frame, irdy, done, retry;
        logic [3:0] cgnt;
        logic [1:0] owner;
        logic       busy, req, start;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [3:0] cq, logic g, logic f, logic i, logic d,
                                logic rt, logic [3:0] cg, logic [1:0] o, logic b, logic rq,
                                logic s);
        vec_t v;
        v.rst = r; v.creq = cq; v.gnt = g; v.frame = f; v.irdy = i; v.done = d; v.retry = rt;
        v.cgnt = cg; v.owner = o; v.busy = b; v.req = rq; v.start = s;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {client_gnt, owner, busy, req, start};
    endfunction

    task automatic drive(logic r, logic [3:0] cq, logic g, logic f, logic i, logic d, logic rt);
        rst = r; client_req = cq; gnt = g; frame_in = f; irdy_in = i;
        xfer_done = d; xfer_retry = rt;
    endtask

    task automatic wait_start(string name, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s: got no start expected start within 20 cycles", name);
        end
    endtask

    task automatic do_reset();
        drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        bit ok;
        vec_t v;
        drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single requester 2, then bus-busy holdoff, then done+retry collision.
        vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 2'd0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0100, 1, 0, 0, 0, 0, 4'b0100, 2'd2, 1, 1, 0));
        vecs.push_back(mk(0, 4'b0100, 1, 0, 0, 0, 0, 4'b0100, 2'd2, 1, 0, 1));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0, 4'b0100, 1, 0, 0, 0, 0, 4'b0100, 2'd2, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 1, 0, 4'b0000, 2'd2, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 0, 4'b0000, 2'd2, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 0, 4'b0001, 2'd0, 1, 1, 0));
        for (int k = 0; k < 10; k++)
            vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 0, 4'b0001, 2'd0, 1, 1, 0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0, 4'b0001, 1, 1, 0, 0, 0, 4'b0001, 2'd0, 1, 1, 0));
        vecs.push_back(mk(0, 4'b0001, 1, 0, 1, 0, 0, 4'b0001, 2'd0, 1, 1, 0));
        vecs.push_back(mk(0, 4'b0001, 1, 0, 0, 0, 0, 4'b0001, 2'd0, 1, 0, 1));
        vecs.push_back(mk(0, 4'b0001, 1, 0, 0, 1, 1, 4'b0000, 2'd0, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0011, 1, 0, 0, 0, 0, 4'b0000, 2'd0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0011, 1, 0, 0, 0, 0, 4'b0010, 2'd1, 1, 1, 0));

        for (int n = 0; n < vecs.size(); n++) begin
            v = vecs[n];
            drive(v.rst, v.creq, v.gnt, v.frame, v.irdy, v.done, v.retry);
            step();
            check($sformatf("vec%0d", n), 32'(outs()),
                  32'({v.cgnt, v.owner, v.busy, v.req, v.start}));
        end

        // Round robin with all requesters active.
        do_reset();
        drive(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 5; t++) begin
            wait_start($sformatf("rr_start%0d", t), ok);
            if (!ok) break;
            check($sformatf("rr_owner%0d", t), 32'(owner), 32'(t % 4));
            step();
            step();
            xfer_done = 1'b1;
            step();
            xfer_done = 1'b0;
        end

        // Retry priority with RETRY_MAX = 2.
        do_reset();
        drive(1'b0, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_start("retry_start0", ok);
        check("retry_owner0", 32'(owner), 32'd1);
        xfer_retry = 1'b1;
        step();
        xfer_retry = 1'b0;
        check("retry_cnt1", 32'(dut.retry_cnt_q), 32'd1);
        wait_start("retry_start1", ok);
        check("retry_owner1", 32'(owner), 32'd1);
        xfer_retry = 1'b1;
        step();
        xfer_retry = 1'b0;
        check("retry_cnt_rot", 32'(dut.retry_cnt_q), 32'd0);
        wait_start("retry_start2", ok);
        check("retry_owner2", 32'(owner), 32'd2);

        // Owner abandons its request while waiting for the bus.
        do_reset();
        drive(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("abandon_req", 32'(outs()), 32'({4'b0010, 2'd1, 1'b1, 1'b1, 1'b0}));
        client_req = 4'b0000;
        step();
        check("abandon_drop", 32'(outs()), 32'({4'b0000, 2'd1, 1'b0, 1'b0, 1'b0}));
        gnt = 1'b1;
        step();
        check("abandon_nostart", 32'(outs()), 32'({4'b0000, 2'd1, 1'b0, 1'b0, 1'b0}));

        // Reset in the middle of a transaction.
        drive(1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_start("rst_start", ok);
        step();
        check("rst_in_xfer", 32'(outs()), 32'({4'b1000, 2'd3, 1'b1, 1'b0, 1'b0}));
        rst = 1'b1;
        step();
        check("rst_outs", 32'(outs()), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
